// File: rtl/note_lane_engine.sv
// Falling-note lane engine: spawns notes, advances them once per frame, scores key-press hits and misses, and flags note pixels per lane.
// Optional build macro STREAK_MULT_EN doubles the hit increment once the pre-hit streak reaches 8.
module note_lane_engine #(
    parameter int NUM_LANES      = 5,
    parameter int NOTES_PER_LANE = 4,
    parameter int NOTE_SIZE      = 16,
    parameter int SPEED          = 2,
    parameter int HIT_Y          = 440,
    parameter int HIT_WIN        = 12,
    parameter int LANE_X0        = 160,
    parameter int LANE_PITCH     = 80,
    localparam int LANE_W        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_clk,
    input  logic [7:0]           keycode,
    input  logic                 spawn_valid,
    input  logic [LANE_W-1:0]    spawn_lane,
    output logic                 spawn_ready,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    output logic [NUM_LANES-1:0] is_note,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic [15:0]          score,
    output logic [7:0]           streak
);

    localparam logic [10:0] WIN_LO    = 11'(HIT_Y - HIT_WIN);
    localparam logic [10:0] WIN_HI    = 11'(HIT_Y + HIT_WIN);
    localparam logic [10:0] STEP      = 11'(SPEED);
    localparam logic [10:0] SIZE      = 11'(NOTE_SIZE);
    localparam logic [7:0]  KEY_FIRST = 8'h1E;
    localparam logic [7:0]  KEY_LAST  = 8'(32'h1E + NUM_LANES - 1);

    logic [NUM_LANES-1:0][NOTES_PER_LANE-1:0] active;
    logic [NUM_LANES-1:0][NOTES_PER_LANE-1:0] hit_sel;
    logic [NUM_LANES-1:0][NOTES_PER_LANE-1:0] alloc_sel;
    logic [9:0]           note_y [NUM_LANES][NOTES_PER_LANE];
    logic [NUM_LANES-1:0] free_any;
    logic [NUM_LANES-1:0] pix_hit;
    logic                 fc_s1, fc_s2, fc_s3, tick;
    logic [7:0]           key_reg;
    logic                 press_pend;
    logic [LANE_W-1:0]    press_lane;
    logic                 spawn_fire, hit_any, miss_any;
    logic [7:0]           streak_next;
    logic [15:0]          score_next;

    assign tick       = fc_s2 & ~fc_s3;
    assign spawn_fire = spawn_valid & spawn_ready;

    function automatic logic [10:0] advanced(input logic [9:0] y);
        return {1'b0, y} + STEP;
    endfunction

    // Per lane: lowest free slot for allocation, lowest in-window slot for a hit, and any note falling past the window.
    always_comb begin
        logic found_hit, found_free;
        found_hit   = 1'b0;
        found_free  = 1'b0;
        hit_sel     = '0;
        alloc_sel   = '0;
        free_any    = '0;
        spawn_ready = 1'b0;
        miss_any    = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            found_hit  = 1'b0;
            found_free = 1'b0;
            for (int s = 0; s < NOTES_PER_LANE; s++) begin
                if (!active[l][s] && !found_free) begin
                    alloc_sel[l][s] = 1'b1;
                    found_free      = 1'b1;
                    free_any[l]     = 1'b1;
                end
                if (press_pend && press_lane == LANE_W'(l) && active[l][s] && !found_hit &&
                    {1'b0, note_y[l][s]} >= WIN_LO && {1'b0, note_y[l][s]} <= WIN_HI) begin
                    hit_sel[l][s] = 1'b1;
                    found_hit     = 1'b1;
                end
                if (tick && active[l][s] && !hit_sel[l][s] && advanced(note_y[l][s]) > WIN_HI)
                    miss_any = 1'b1;
            end
            if (spawn_lane == LANE_W'(l))
                spawn_ready = free_any[l];
        end
    end

    // A miss clears the streak before a same-cycle hit increments it.
    always_comb begin
        logic [7:0]  base;
        logic [15:0] inc;
        logic [16:0] sum;
        hit_any = |hit_sel;
        base    = miss_any ? 8'd0 : streak;
`ifdef STREAK_MULT_EN
        inc = (base >= 8'd8) ? 16'd2 : 16'd1;
`else
        inc = 16'd1;
`endif
        sum         = {1'b0, score} + {1'b0, inc};
        streak_next = base;
        score_next  = score;
        if (hit_any) begin
            streak_next = (base == 8'hFF) ? 8'hFF : base + 8'd1;
            score_next  = sum[16] ? 16'hFFFF : sum[15:0];
        end
    end

    always_comb begin
        logic [10:0] x0, dx, dy, ny;
        pix_hit = '0;
        dx      = {1'b0, DrawX};
        dy      = {1'b0, DrawY};
        x0      = '0;
        ny      = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            x0 = 11'(LANE_X0 + l * LANE_PITCH);
            for (int s = 0; s < NOTES_PER_LANE; s++) begin
                ny = {1'b0, note_y[l][s]};
                if (active[l][s] && dx >= x0 && dx < x0 + SIZE && dy >= ny && dy < ny + SIZE)
                    pix_hit[l] = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fc_s1      <= 1'b0;
            fc_s2      <= 1'b0;
            fc_s3      <= 1'b0;
            key_reg    <= 8'd0;
            press_pend <= 1'b0;
            press_lane <= '0;
            active     <= '0;
            for (int l = 0; l < NUM_LANES; l++)
                for (int s = 0; s < NOTES_PER_LANE; s++)
                    note_y[l][s] <= 10'd0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            score      <= 16'd0;
            streak     <= 8'd0;
            is_note    <= '0;
        end else begin
            fc_s1      <= frame_clk;
            fc_s2      <= fc_s1;
            fc_s3      <= fc_s2;
            key_reg    <= keycode;
            press_pend <= (keycode >= KEY_FIRST) && (keycode <= KEY_LAST) && (keycode != key_reg);
            press_lane <= LANE_W'(keycode - KEY_FIRST);
            // A hit note is removed rather than advanced; a freshly spawned note skips this tick.
            for (int l = 0; l < NUM_LANES; l++) begin
                for (int s = 0; s < NOTES_PER_LANE; s++) begin
                    if (hit_sel[l][s]) begin
                        active[l][s] <= 1'b0;
                    end else if (tick && active[l][s]) begin
                        if (advanced(note_y[l][s]) > WIN_HI)
                            active[l][s] <= 1'b0;
                        else
                            note_y[l][s] <= note_y[l][s] + 10'(SPEED);
                    end
                    if (spawn_fire && spawn_lane == LANE_W'(l) && alloc_sel[l][s]) begin
                        active[l][s] <= 1'b1;
                        note_y[l][s] <= 10'd0;
                    end
                end
            end
            hit_pulse  <= hit_any;
            miss_pulse <= miss_any;
            streak     <= streak_next;
            score      <= score_next;
            is_note    <= pix_hit;
        end
    end

endmodule

// File: tb/tb_note_lane_engine.sv
// Directed self-checking bench for note_lane_engine: hits, misses, full lanes, pixel hits, tick/hit overlap and async reset.
module tb_note_lane_engine;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [7:0]  keycode;
    logic        spawn_valid;
    logic [2:0]  spawn_lane;
    logic        spawn_ready;
    logic [9:0]  DrawX, DrawY;
    logic [4:0]  is_note;
    logic        hit_pulse, miss_pulse;
    logic [15:0] score;
    logic [7:0]  streak;

    int tests    = 0;
    int fails    = 0;
    int hit_cnt  = 0;
    int miss_cnt = 0;
    int hit_base, miss_base;

    note_lane_engine dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .spawn_valid(spawn_valid), .spawn_lane(spawn_lane), .spawn_ready(spawn_ready),
        .DrawX(DrawX), .DrawY(DrawY), .is_note(is_note),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score(score), .streak(streak)
    );

    always #5 Clk = ~Clk;

    // Counts high cycles of each pulse, so a pulse wider than one Clk shows up as an extra count.
    always @(posedge Clk) begin
        if (hit_pulse === 1'b1) hit_cnt++;
        if (miss_pulse === 1'b1) miss_cnt++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y);
        DrawX = x;
        DrawY = y;
        @(negedge Clk);
    endtask

    task automatic frame_ticks(input int n);
        repeat (n) begin
            frame_clk = 1'b1;
            repeat (3) @(negedge Clk);
            frame_clk = 1'b0;
            repeat (3) @(negedge Clk);
        end
    endtask

    task automatic spawn_note(input logic [2:0] lane);
        spawn_lane  = lane;
        spawn_valid = 1'b1;
        @(negedge Clk);
        spawn_valid = 1'b0;
    endtask

    task automatic press_key(input logic [7:0] key);
        keycode = key;
        repeat (4) @(negedge Clk);
        keycode = 8'h00;
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00; spawn_valid = 1'b0;
        spawn_lane = 3'd0; DrawX = 10'd0; DrawY = 10'd0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checkOutput("reset_score", 32'(score), 32'd0);
        checkOutput("reset_streak", 32'(streak), 32'd0);
        checkOutput("reset_is_note", 32'(is_note), 32'd0);
        checkOutput("reset_pulses", 32'({hit_pulse, miss_pulse}), 32'd0);
        checkOutput("reset_ready", 32'(spawn_ready), 32'd1);

        // Hit on lane 0 at y=428
        spawn_note(3'd0);
        frame_ticks(214);
        applyStimulus(10'd160, 10'd443);
        checkOutput("lane0_pixel_before_hit", 32'(is_note), 32'b00001);
        press_key(8'h1E);
        checkOutput("hit1_count", 32'(hit_cnt), 32'd1);
        checkOutput("hit1_score", 32'(score), 32'd1);
        checkOutput("hit1_streak", 32'(streak), 32'd1);
        applyStimulus(10'd160, 10'd443);
        checkOutput("hit1_slot_freed", 32'(is_note), 32'd0);

        // Miss on lane 3: y=452 is still in window, the next tick misses
        spawn_note(3'd3);
        frame_ticks(226);
        checkOutput("miss_not_yet", 32'(miss_cnt), 32'd0);
        frame_ticks(1);
        checkOutput("miss_count", 32'(miss_cnt), 32'd1);
        checkOutput("miss_streak", 32'(streak), 32'd0);
        checkOutput("miss_score", 32'(score), 32'd1);

        // Full lane 2
        repeat (4) spawn_note(3'd2);
        spawn_lane = 3'd2; #1;
        checkOutput("full_lane2_ready", 32'(spawn_ready), 32'd0);
        spawn_lane = 3'd1; #1;
        checkOutput("lane1_ready", 32'(spawn_ready), 32'd1);
        spawn_lane = 3'd5; #1;
        checkOutput("bad_lane_ready", 32'(spawn_ready), 32'd0);
        spawn_note(3'd2);
        frame_ticks(214);
        keycode = 8'h20;
        repeat (10) @(negedge Clk);
        checkOutput("held_key_one_hit", 32'(hit_cnt), 32'd2);
        spawn_lane = 3'd2; #1;
        checkOutput("lane2_ready_after_hit", 32'(spawn_ready), 32'd1);
        keycode = 8'h00;
        repeat (2) @(negedge Clk);
        repeat (3) press_key(8'h20);
        checkOutput("lane2_hits", 32'(hit_cnt), 32'd5);
        checkOutput("lane2_streak", 32'(streak), 32'd4);
        checkOutput("lane2_score", 32'(score), 32'd5);
        applyStimulus(10'd320, 10'd0);
        checkOutput("dropped_spawn_absent", 32'(is_note), 32'd0);
        press_key(8'h1F);
        checkOutput("empty_press_no_hit", 32'(hit_cnt), 32'd5);
        checkOutput("empty_press_no_miss", 32'(miss_cnt), 32'd1);

        // Pixel overlap, lane 1 note at y=100
        spawn_note(3'd1);
        frame_ticks(50);
        applyStimulus(10'd240, 10'd100);
        checkOutput("pix_corner", 32'(is_note), 32'b00010);
        applyStimulus(10'd256, 10'd100);
        checkOutput("pix_right_edge", 32'(is_note), 32'd0);
        applyStimulus(10'd240, 10'd116);
        checkOutput("pix_bottom_edge", 32'(is_note), 32'd0);
        applyStimulus(10'd239, 10'd100);
        checkOutput("pix_left_edge", 32'(is_note), 32'd0);
        applyStimulus(10'd255, 10'd115);
        checkOutput("pix_far_corner", 32'(is_note), 32'b00010);

        #2 Reset = 1'b1;
        #1;
        checkOutput("async_reset_is_note", 32'(is_note), 32'd0);
        checkOutput("async_reset_score", 32'(score), 32'd0);
        checkOutput("async_reset_streak", 32'(streak), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // Hit and tick in the same cycle with the note at y=452
        spawn_note(3'd0);
        frame_ticks(226);
        hit_base  = hit_cnt;
        miss_base = miss_cnt;
        frame_clk = 1'b1;
        @(negedge Clk);
        keycode = 8'h1E;
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        keycode = 8'h00;
        repeat (2) @(negedge Clk);
        checkOutput("tick_hit_count", 32'(hit_cnt - hit_base), 32'd1);
        checkOutput("tick_hit_no_miss", 32'(miss_cnt - miss_base), 32'd0);
        checkOutput("tick_hit_score", 32'(score), 32'd1);
        checkOutput("tick_hit_streak", 32'(streak), 32'd1);
        applyStimulus(10'd160, 10'd460);
        checkOutput("tick_hit_removed", 32'(is_note), 32'd0);

        // Nine consecutive hits from a clean reset
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        hit_base = hit_cnt;
        spawn_note(3'd0); spawn_note(3'd0); spawn_note(3'd1); spawn_note(3'd1);
        spawn_note(3'd2); spawn_note(3'd2); spawn_note(3'd3); spawn_note(3'd3);
        spawn_note(3'd4);
        frame_ticks(214);
        press_key(8'h1E); press_key(8'h1E); press_key(8'h1F); press_key(8'h1F);
        press_key(8'h20); press_key(8'h20); press_key(8'h21); press_key(8'h21);
        press_key(8'h22);
        checkOutput("nine_hits_count", 32'(hit_cnt - hit_base), 32'd9);
        checkOutput("nine_hits_streak", 32'(streak), 32'd9);
`ifdef STREAK_MULT_EN
        checkOutput("nine_hits_score", 32'(score), 32'd10);
`else
        checkOutput("nine_hits_score", 32'(score), 32'd9);
`endif

        // Reset in the middle of a frame pulse with a note on screen
        spawn_note(3'd4);
        applyStimulus(10'd480, 10'd0);
        checkOutput("lane4_pixel", 32'(is_note), 32'b10000);
        frame_clk = 1'b1;
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        checkOutput("midframe_reset_score", 32'(score), 32'd0);
        checkOutput("midframe_reset_streak", 32'(streak), 32'd0);
        checkOutput("midframe_reset_is_note", 32'(is_note), 32'd0);
        checkOutput("midframe_reset_pulses", 32'({hit_pulse, miss_pulse}), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        frame_clk = 1'b0;
        @(negedge Clk);
        spawn_lane = 3'd4; #1;
        checkOutput("post_reset_ready", 32'(spawn_ready), 32'd1);
        applyStimulus(10'd480, 10'd0);
        checkOutput("post_reset_pixel", 32'(is_note), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
